// File: rtl/tbl_stream_ctrl_if.sv
// rtl/tbl_stream_ctrl_if.sv - host/consumer bundle for tbl_stream_ctrl; loop signal exists only with TBL_STREAM_LOOP_EN
interface tbl_stream_ctrl_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW:0]   len;
  logic          s_wait;
`ifdef TBL_STREAM_LOOP_EN
  logic          loop;
`endif
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, len, s_wait,
`ifdef TBL_STREAM_LOOP_EN
    output loop,
`endif
    input  out_valid, out_data, out_idx, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, len, s_wait,
`ifdef TBL_STREAM_LOOP_EN
    input  loop,
`endif
    output out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/tbl_stream_ctrl.sv
// rtl/tbl_stream_ctrl.sv - table-driven stream sequencer; optional wrap-around streaming under TBL_STREAM_LOOP_EN
module tbl_stream_ctrl #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  tbl_stream_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] idx, idx_d, last, last_d, idx_inc;
  logic [DW-1:0] data, data_d;
  logic          valid, valid_d, busy_r, busy_d, done_r, done_d;
  logic          tbl_we, xfer, loop_now;
  logic [AW:0]   len_m1;

  assign tbl_we  = bus.wr_en && (state != ST_SEND);
  assign xfer    = valid && !bus.s_wait;
  assign idx_inc = idx + AW'(1);
  assign len_m1  = bus.len - (AW+1)'(1);
`ifdef TBL_STREAM_LOOP_EN
  assign loop_now = bus.loop;
`else
  assign loop_now = 1'b0;
`endif

  assign bus.out_valid = valid;
  assign bus.out_data  = data;
  assign bus.out_idx   = idx;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    last_d  = last;
    data_d  = data;
    valid_d = valid;
    busy_d  = busy_r;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEND;
            idx_d   = '0;
            last_d  = (bus.len > (AW+1)'(DEPTH)) ? {AW{1'b1}} : len_m1[AW-1:0];
            valid_d = 1'b1;
            busy_d  = 1'b1;
            // A write landing on the same edge must be visible to the first beat.
            data_d  = (tbl_we && bus.wr_addr == '0) ? bus.wr_data : mem[0];
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (idx != last) begin
            idx_d  = idx_inc;
            data_d = mem[idx_inc];
          end else if (loop_now) begin
            idx_d  = '0;
            data_d = mem[0];
          end else begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      idx    <= '0;
      last   <= '0;
      data   <= '0;
      valid  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (enable) begin
      state  <= state_d;
      idx    <= idx_d;
      last   <= last_d;
      data   <= data_d;
      valid  <= valid_d;
      busy_r <= busy_d;
      done_r <= done_d;
    end
  end

  // Table storage is deliberately outside reset so its contents survive it.
  always_ff @(posedge clk) begin
    if (rstn && enable && tbl_we)
      mem[bus.wr_addr] <= bus.wr_data;
  end
endmodule

// File: tb/tb_tbl_stream_ctrl.sv
// tb/tb_tbl_stream_ctrl.sv - self-checking bench for tbl_stream_ctrl (loop case when TBL_STREAM_LOOP_EN is defined)
module tb_tbl_stream_ctrl;
  localparam int DW = 8, DEPTH = 16, AW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  tbl_stream_ctrl_if #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) bus ();
  tbl_stream_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bus(bus)
  );

  typedef struct {
    int len;
    int beats;
    int last_data;
  } vec_t;

  int n_checks = 0, n_fail = 0, done_cnt = 0;
  int got_d[$], got_i[$];
  int mtab[DEPTH];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic x, en_e, rst_e;
    int d, i;
    x     = bus.out_valid && !bus.s_wait && enable && rstn;
    en_e  = enable;
    rst_e = rstn;
    d = int'(bus.out_data);
    i = int'(bus.out_idx);
    @(posedge clk);
    #1;
    if (x) begin
      got_d.push_back(d);
      got_i.push_back(i);
    end
    if (bus.done && en_e && rst_e) done_cnt++;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.start = 1'b0; bus.s_wait = 1'b0; enable = 1'b1;
`ifdef TBL_STREAM_LOOP_EN
    bus.loop = 1'b0;
`endif
  endtask

  task automatic compare_stream(input string nm, input int ln);
    int n;
    n = (ln > DEPTH) ? DEPTH : ln;
    check({nm, "_count"}, got_d.size(), n);
    for (int k = 0; k < n && k < got_d.size(); k++) begin
      check({nm, "_data"}, got_d[k], mtab[k]);
      check({nm, "_idx"}, got_i[k], k);
    end
  endtask

  // Starts a stream and runs to its done pulse, then returns the DUT to IDLE.
  task automatic run_stream(input int ln, input bit rnd, output int nt);
    int d0;
    got_d.delete(); got_i.delete();
    d0 = done_cnt;
    bus.len = (AW+1)'(ln);
    bus.start = 1'b1;
    enable = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    nt = 1;
    while (done_cnt == d0 && nt < 400) begin
      if (rnd) begin
        bus.s_wait  = ($urandom % 3) == 0;
        enable      = ($urandom % 4) != 0;
        bus.wr_en   = $urandom % 2;
        bus.wr_addr = AW'($urandom);
        bus.wr_data = DW'($urandom);
        bus.start   = $urandom % 2;
        bus.len     = (AW+1)'($urandom);
      end
      tick();
      nt++;
    end
    idle_inputs();
    check("stream_done", done_cnt - d0, 1);
    tick();
  endtask

  vec_t vecs[6];
  int nt, d0;

  initial begin
    vecs[0] = '{16, 16, 8'h1F};
    vecs[1] = '{0, 0, 0};
    vecs[2] = '{31, 16, 8'h1F};
    vecs[3] = '{1, 1, 8'h10};
    vecs[4] = '{4, 4, 8'h13};
    vecs[5] = '{17, 16, 8'h1F};

    idle_inputs();
    bus.len = '0; bus.wr_addr = '0; bus.wr_data = '0;
    rstn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      enable = $urandom % 2; bus.start = $urandom % 2; bus.s_wait = $urandom % 2;
      bus.wr_en = $urandom % 2; bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
      bus.len = (AW+1)'($urandom);
      tick();
    end
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_idx", bus.out_idx, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    rstn = 1'b1;
    idle_inputs();
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(8'h10 + i);
      mtab[i] = 8'h10 + i;
      tick();
    end
    bus.wr_en = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_stream(vecs[v].len, 1'b0, nt);
      compare_stream("vec", vecs[v].len);
      check("vec_latency", nt, vecs[v].beats + 1);
      if (vecs[v].beats > 0)
        check("vec_last", got_d[got_d.size()-1], vecs[v].last_data);
    end

    // Stall on beat 2, freeze on beat 3.
    got_d.delete(); got_i.delete();
    d0 = done_cnt;
    bus.len = 5'd4; bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    bus.s_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_data", bus.out_data, 8'h11);
      check("stall_idx", bus.out_idx, 1);
    end
    bus.s_wait = 1'b0;
    tick();
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("freeze_data", bus.out_data, 8'h12);
      check("freeze_valid", bus.out_valid, 1);
    end
    enable = 1'b1;
    for (int c = 0; c < 2; c++) tick();
    compare_stream("stall", 4);
    check("stall_done", done_cnt - d0, 1);
    tick();

    // Writes and start while busy must be ignored.
    got_d.delete(); got_i.delete();
    d0 = done_cnt;
    bus.len = 5'd16; bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 8'hAA; bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    for (int c = 0; c < 40 && done_cnt == d0; c++) tick();
    compare_stream("busy_prot", 16);
    tick(); tick();
    check("no_queued_start", bus.out_valid, 0);
    run_stream(1, 1'b0, nt);
    compare_stream("after_prot", 1);

    // Reset while beat 5 is presented.
    got_d.delete(); got_i.delete();
    d0 = done_cnt;
    bus.len = 5'd16; bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("pre_rst_data", bus.out_data, 8'h14);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data", bus.out_data, 0);
    check("midrst_busy", bus.busy, 0);
    for (int c = 0; c < 3; c++) tick();
    check("midrst_no_done", done_cnt - d0, 0);

`ifdef TBL_STREAM_LOOP_EN
    got_d.delete(); got_i.delete();
    d0 = done_cnt;
    bus.loop = 1'b1;
    bus.len = 5'd3; bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int c = 0; c < 40 && done_cnt == d0; c++) begin
      bus.loop = got_d.size() < 7;
      tick();
    end
    bus.loop = 1'b0;
    check("loop_count", got_d.size(), 9);
    for (int k = 0; k < 9 && k < got_d.size(); k++)
      check("loop_data", got_d[k], 8'h10 + (k % 3));
    check("loop_done", done_cnt - d0, 1);
    tick();
`endif

    // Randomized streams against the table model.
    for (int s = 0; s < 20; s++) begin
      int ln, nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        bus.wr_en = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
        mtab[bus.wr_addr] = int'(bus.wr_data);
        tick();
      end
      bus.wr_en = $urandom % 2;
      bus.wr_addr = ($urandom % 2) ? '0 : AW'($urandom);
      bus.wr_data = DW'($urandom);
      if (bus.wr_en) mtab[bus.wr_addr] = int'(bus.wr_data);
      ln = $urandom_range(0, 31);
      run_stream(ln, 1'b1, nt);
      compare_stream("rand", ln);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
